// File: rtl/coffee_dispense_controller_if.sv
// Bundles the selection-side handshake and the valve/lookup side of the dispense controller.
// Controller uses the slave modport; the panel/lookup/valve side uses master.
interface coffee_dispense_controller_if;
   logic       start;
   logic [2:0] coffee_sel;
   logic       no_sugar;
   logic       cancel;
   logic [1:0] ingredient_time;
   logic [2:0] coffee_type;
   logic [2:0] state;
   logic [4:0] valve_en;
   logic       busy;
   logic       done;
   logic       error;

   modport master (
      output start, coffee_sel, no_sugar, cancel, ingredient_time,
      input  coffee_type, state, valve_en, busy, done, error
   );

   modport slave (
      input  start, coffee_sel, no_sugar, cancel, ingredient_time,
      output coffee_type, state, valve_en, busy, done, error
   );
endinterface

// File: rtl/coffee_dispense_controller.sv
// Sequences water/coffee/milk/chocolate/sugar valves, each open for lookup-time x CYCLES_PER_UNIT cycles.
// Drink takes 10 + C*sum(t) cycles to DONE; start is level-sampled in IDLE only, cancel aborts anywhere else.
module coffee_dispense_controller #(
   parameter int CYCLES_PER_UNIT = 50000000,
   parameter int PRESC_W         = 26
) (
   input logic clk,
   input logic rst_n,
   coffee_dispense_controller_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, POUR, NEXT, DONE} fsm_t;

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CYCLES_PER_UNIT - 1);

   fsm_t               fsm_q, fsm_d;
   logic [2:0]         type_q;
   logic [2:0]         stage_q;
   logic [PRESC_W-1:0] presc_q;
   logic [1:0]         units_q;
   logic               skip_sugar_q;
   logic               error_q;

   logic start_ok, start_bad, abort, skip_stage, unit_wrap;

   assign start_ok   = bus.start && !bus.coffee_sel[2];
   assign start_bad  = bus.start &&  bus.coffee_sel[2];
   assign abort      = (fsm_q != IDLE) && bus.cancel;
   assign skip_stage = (bus.ingredient_time == 2'd0) || ((stage_q == 3'd4) && skip_sugar_q);
   assign unit_wrap  = (presc_q == PRESC_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_q <= IDLE;
      else        fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d = fsm_q;
      if (abort) begin
         fsm_d = IDLE;
      end else begin
         case (fsm_q)
            IDLE:    if (start_ok) fsm_d = LOAD;
            LOAD:    fsm_d = skip_stage ? NEXT : POUR;
            POUR:    if (unit_wrap && (units_q == 2'd1)) fsm_d = NEXT;
            NEXT:    fsm_d = (stage_q == 3'd4) ? DONE : LOAD;
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         type_q       <= 3'd0;
         stage_q      <= 3'd0;
         presc_q      <= '0;
         units_q      <= 2'd0;
         skip_sugar_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         error_q <= (fsm_q == IDLE) && start_bad;
         if (abort) begin
            stage_q <= 3'd0;
            presc_q <= '0;
            units_q <= 2'd0;
         end else begin
            case (fsm_q)
               IDLE: if (start_ok) begin
                  type_q       <= bus.coffee_sel;
                  skip_sugar_q <= bus.no_sugar;
                  stage_q      <= 3'd0;
               end
               LOAD: if (!skip_stage) begin
                  units_q <= bus.ingredient_time;
                  presc_q <= '0;
               end
               // Unit counter only moves on prescaler wrap, so the pour is exactly t*C cycles.
               POUR: if (unit_wrap) begin
                  presc_q <= '0;
                  units_q <= units_q - 2'd1;
               end else begin
                  presc_q <= presc_q + PRESC_W'(1);
               end
               NEXT: if (stage_q != 3'd4) stage_q <= stage_q + 3'd1;
               DONE: stage_q <= 3'd0;
               default: ;
            endcase
         end
      end
   end

   // Decoded from registered state only, so an async reset closes the valves immediately.
   always_comb begin
      bus.valve_en = 5'b00000;
      bus.busy     = (fsm_q != IDLE);
      bus.done     = (fsm_q == DONE);
      if (fsm_q == POUR) bus.valve_en = 5'b00001 << stage_q;
   end

   assign bus.coffee_type = type_q;
   assign bus.state       = stage_q;
   assign bus.error       = error_q;
endmodule

// File: doc/coffee_dispense_controller.md
Name: coffee_dispense_controller

Overview:
- Sequences one drink through the five ingredient stages in fixed order: water 0, coffee 1, milk 2, chocolate 3, sugar 4.
- Drives the stage index and latched drink type into the existing per-coffee time lookup, reads back the stage time in units, and opens the matching valve for that many time units.
- Sits between the front-panel selection logic and the valve drivers.

Parameters:
- CYCLES_PER_UNIT, 50000000: clk cycles per ingredient time unit (1 s at 50 MHz); must be ≥2; benches use 4.
- PRESC_W, 26: prescaler counter width; must satisfy 2^PRESC_W ≥ CYCLES_PER_UNIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a drink; sampled only in IDLE.
- coffee_sel  in  3  drink type: 0 espresso, 1 with milk, 2 cappuccino, 3 mocaccino; 4–7 invalid.
- no_sugar  in  1  sampled with start; 1 skips stage 4.
- cancel  in  1  abort the drink in progress.
- ingredient_time  in  2  stage time in units, from the lookup (combinational).
- coffee_type  out  3  latched drink type, to the lookup.
- state  out  3  current stage index 0–4, to the lookup.
- valve_en  out  5  one-hot valve enables; bit i = stage i.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a drink completes normally.
- error  out  1  one-cycle pulse when start arrives with an invalid type.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; coffee_type=0, state=0, prescaler=0, unit counter=0, sugar-skip flag=0.
  - valve_en=0, busy=0, done=0, error=0.
  - Reset mid-pour closes all valves immediately, with no clock required.
- All outputs are registered or decoded only from registered state; no input-to-output combinational paths.
- FSM states: IDLE, LOAD, POUR, NEXT, DONE.
- IDLE:
  - start=1 with coffee_sel≤3: latch coffee_type and no_sugar, set state=0, go to LOAD.
  - start=1 with coffee_sel≥4: error=1 for the next cycle, stay in IDLE, keep coffee_type unchanged.
  - start is level-sampled. If start is still high when the FSM returns to IDLE, a new drink begins.
- LOAD (exactly 1 cycle):
  - Go to NEXT if ingredient_time=0, or if state=4 and the sugar-skip flag is set.
  - Otherwise load the unit counter with ingredient_time, clear the prescaler, go to POUR.
- POUR:
  - valve_en = 1<<state.
  - Prescaler counts 0..CYCLES_PER_UNIT-1, then wraps.
  - On each wrap the unit counter decrements. The wrap that brings it from 1 to 0 moves to NEXT.
  - Therefore POUR lasts exactly ingredient_time*CYCLES_PER_UNIT cycles.
  - valve_en drops on the same edge as the exit from POUR.
- NEXT (1 cycle): state=4 goes to DONE; otherwise state increments and goes to LOAD.
- DONE (1 cycle): done=1, valve_en=0, then go to IDLE; state returns to 0.
- cancel:
  - In any non-IDLE state, cancel=1 forces IDLE on the next edge: valve_en=0, counters cleared, no done pulse.
  - cancel takes priority over every other transition. It is ignored in IDLE.
- Inputs not sampled outside the stated points: coffee_sel and no_sugar are ignored while busy, so changes mid-drink have no effect.
- Timing for a drink with stage times t0..t4 and C=CYCLES_PER_UNIT:
  - From the start-sampling edge to entering DONE: 10 + C*Σt cycles. Skipped stages cost LOAD+NEXT = 2 cycles.
  - busy is high for 11 + C*Σt cycles.
- Widths: unit counter 2 bits. The prescaler compares against CYCLES_PER_UNIT-1 at PRESC_W bits, with no overflow.

Test Plan:
- Reset with C=4, pulse start with coffee_sel=0, no_sugar=0 (times 2,3,0,0,1):
  - valve_en=00001 for 8 cycles, 00010 for 12, 10000 for 4; milk and chocolate are never opened.
  - done pulses once, 34 cycles after the start edge; busy is high for 35 cycles.
- coffee_sel=3, no_sugar=1 (times 1,1,1,2,1):
  - valves 0..3 open for 4,4,4,8 cycles; bit 4 is never set.
  - done arrives 10+4*5=30 cycles after start.
- coffee_sel=5 in IDLE → error=1 for exactly 1 cycle; busy stays 0; valve_en stays 0; coffee_type unchanged.
- Drink 2 in progress, cancel=1 during milk POUR (valve_en=00100) → next edge: valve_en=0, busy=0, no done pulse.
  - A following start with coffee_sel=1 runs the full sequence from water.
- Deassert rst_n asynchronously mid-coffee POUR → valve_en=0 and busy=0 before the next clk edge; after release the FSM is in IDLE with state=0.
- Hold start=1 continuously with coffee_sel=2 → back-to-back drinks; exactly 1 IDLE cycle between done and the next busy; the coffee_sel change to 0 mid-drink is ignored until the next IDLE.
